uart_rx_frame_sampler: RTL and testbench

Receive-side UART front end: synchronises the asynchronous serial input, detects start bits, samples each data bit at mid-bit using a clock-cycle counter, and checks the stop bit. A good frame produces a parallel byte and a one-cycle `o_data_valid` strobe. That strobe feeds the control unit's one-cycle strobe delay stage, which aligns it with the datapath register write. Frames with a bad stop bit produce `o_framing_error` instead.

---
 rtl/uart_rx_frame_sampler.sv | 143 ++++++++++++++
 tb/tb_uart_rx_frame_sampler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_sampler.sv
// UART receive front end: two-flop synchroniser, mid-bit sampling,
// stop-bit check, one-cycle valid / framing-error strobes.
module uart_rx_frame_sampler #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_clock,
  input  logic                 i_async_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  output logic                 o_framing_error,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAITH = 3'd4;

  logic                 sync1_q;
  logic                 sync2_q;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  // Sync flops idle high so reset never looks like a start bit.
  always_ff @(posedge i_clock or posedge i_async_reset) begin
    if (i_async_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!sync2_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = sync2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAITH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A held-low line (break) must go high before a new start.
      S_WAITH: begin
        if (sync2_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_async_reset) begin
    if (i_async_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_data          = data_q;
  assign o_data_valid    = valid_q;
  assign o_framing_error = ferr_q;
  assign o_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Directed bench for uart_rx_frame_sampler at 16 clocks/bit,
// 8 data bits; strobe edges are checked against hand-computed t0 offsets.
module tb_uart_rx_frame_sampler;

  localparam int CPB = 16;

  logic       i_clock;
  logic       i_async_reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_framing_error;
  logic       o_busy;

  uart_rx_frame_sampler #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .i_clock        (i_clock),
    .i_async_reset  (i_async_reset),
    .i_rx           (i_rx),
    .o_data         (o_data),
    .o_data_valid   (o_data_valid),
    .o_framing_error(o_framing_error),
    .o_busy         (o_busy)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  int n_valid, n_ferr, n_both, n_rise;
  int first_valid, last_valid, last_ferr;
  int busy_rise, busy_fall;
  logic [7:0] first_data, last_data;
  logic busy_prev = 1'b0;

  // Outputs change only on posedge; observe them on negedge.
  always @(negedge i_clock) begin
    if (o_data_valid) begin
      if (n_valid == 0) begin
        first_valid = cyc;
        first_data  = o_data;
      end
      n_valid++;
      last_valid = cyc;
      last_data  = o_data;
    end
    if (o_framing_error) begin
      n_ferr++;
      last_ferr = cyc;
    end
    if (o_data_valid && o_framing_error) n_both++;
    if (o_busy && !busy_prev) begin
      busy_rise = cyc;
      n_rise++;
    end
    if (!o_busy && busy_prev) busy_fall = cyc;
    busy_prev = o_busy;
  end

  task automatic clear_stats();
    n_valid     = 0;
    n_ferr      = 0;
    n_rise      = 0;
    first_valid = -1;
    last_valid  = -1;
    last_ferr   = -1;
    busy_rise   = -1;
    busy_fall   = -1;
    first_data  = 8'h00;
    last_data   = 8'h00;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  // Call right after a negedge; t0 is the edge that captures the start bit.
  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            output int t0);
    t0   = cyc + 1;
    i_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      wait_cycles(CPB);
    end
    i_rx = stop;
    wait_cycles(CPB);
  endtask

  int t0, t1;
  logic [7:0] rb;

  initial begin
    n_both = 0;
    clear_stats();
    i_rx          = 1'b1;
    i_async_reset = 1'b0;
    #1 i_async_reset = 1'b1;
    wait_cycles(3);
    check("rst_data",  32'(o_data), 32'h00);
    check("rst_valid", 32'(o_data_valid), 32'h0);
    check("rst_ferr",  32'(o_framing_error), 32'h0);
    check("rst_busy",  32'(o_busy), 32'h0);
    i_async_reset = 1'b0;

    // Idle line
    clear_stats();
    wait_cycles(200);
    #1;
    check("idle_valid", 32'(n_valid), 32'd0);
    check("idle_ferr",  32'(n_ferr), 32'd0);
    check("idle_busy",  32'(n_rise), 32'd0);
    check("idle_data",  32'(o_data), 32'h00);

    // Single good frame 0xA5
    @(negedge i_clock);
    clear_stats();
    send_frame(8'hA5, 1'b1, t0);
    wait_cycles(10);
    #1;
    check("a5_nvalid", 32'(n_valid), 32'd1);
    check("a5_edge",   32'(last_valid), 32'(t0 + 154));
    check("a5_byte",   32'(last_data), 32'hA5);
    check("a5_data",   32'(o_data), 32'hA5);
    check("a5_brise",  32'(busy_rise), 32'(t0 + 2));
    check("a5_bfall",  32'(busy_fall), 32'(t0 + 154));
    check("a5_ferr",   32'(n_ferr), 32'd0);

    // Back-to-back 0x3C, 0xFF
    clear_stats();
    send_frame(8'h3C, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    wait_cycles(10);
    #1;
    check("b2b_nvalid", 32'(n_valid), 32'd2);
    check("b2b_first",  32'(first_valid), 32'(t0 + 154));
    check("b2b_gap",    32'(last_valid - first_valid), 32'd160);
    check("b2b_byte0",  32'(first_data), 32'h3C);
    check("b2b_byte1",  32'(last_data), 32'hFF);
    check("b2b_data",   32'(o_data), 32'hFF);

    // 4-cycle low glitch
    @(negedge i_clock);
    clear_stats();
    t0   = cyc + 1;
    i_rx = 1'b0;
    wait_cycles(4);
    i_rx = 1'b1;
    wait_cycles(30);
    #1;
    check("gl_nvalid", 32'(n_valid), 32'd0);
    check("gl_brise",  32'(busy_rise), 32'(t0 + 2));
    check("gl_bfall",  32'(busy_fall), 32'(t0 + 10));
    check("gl_busy",   32'(o_busy), 32'h0);
    check("gl_data",   32'(o_data), 32'hFF);

    // 0x55 with low stop bit, line held low, then good 0x81
    @(negedge i_clock);
    clear_stats();
    send_frame(8'h55, 1'b0, t0);
    wait_cycles(50);
    i_rx = 1'b1;
    wait_cycles(20);
    #1;
    check("fe_nferr",  32'(n_ferr), 32'd1);
    check("fe_edge",   32'(last_ferr), 32'(t0 + 154));
    check("fe_nvalid", 32'(n_valid), 32'd0);
    check("fe_data",   32'(o_data), 32'hFF);
    check("fe_bfall",  32'(busy_fall), 32'(t0 + 212));
    check("fe_nrise",  32'(n_rise), 32'd1);
    @(negedge i_clock);
    clear_stats();
    send_frame(8'h81, 1'b1, t1);
    wait_cycles(10);
    #1;
    check("fe81_nvalid", 32'(n_valid), 32'd1);
    check("fe81_edge",   32'(last_valid), 32'(t1 + 154));
    check("fe81_data",   32'(o_data), 32'h81);
    check("fe81_nferr",  32'(n_ferr), 32'd0);

    // Async reset in the middle of data bit 4 of 0xC3
    @(negedge i_clock);
    clear_stats();
    rb   = 8'hC3;
    i_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      i_rx = rb[i];
      wait_cycles(CPB);
    end
    i_rx = rb[4];
    wait_cycles(CPB / 2);
    check("mr_busy_pre", 32'(o_busy), 32'h1);
    #2 i_async_reset = 1'b1;
    #1;
    check("mr_data",  32'(o_data), 32'h00);
    check("mr_busy",  32'(o_busy), 32'h0);
    check("mr_valid", 32'(o_data_valid), 32'h0);
    check("mr_ferr",  32'(o_framing_error), 32'h0);
    wait_cycles(3);
    i_rx          = 1'b1;
    i_async_reset = 1'b0;
    wait_cycles(200);
    #1;
    check("mr_nvalid", 32'(n_valid), 32'd0);
    check("mr_nferr",  32'(n_ferr), 32'd0);
    check("mr_data2",  32'(o_data), 32'h00);
    @(negedge i_clock);
    clear_stats();
    send_frame(8'h5A, 1'b1, t0);
    wait_cycles(10);
    #1;
    check("mr5a_nvalid", 32'(n_valid), 32'd1);
    check("mr5a_edge",   32'(last_valid), 32'(t0 + 154));
    check("mr5a_data",   32'(o_data), 32'h5A);

    check("never_both", 32'(n_both), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
